// File: rtl/vita2000_pkg.sv
// Shared constants, state encoding and pixel helpers for the VITA2000 capture path.
package vita2000_pkg;

    localparam int LANES        = 4;
    localparam int RAW_W        = 10;
    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 8;
    localparam int COL_W        = 12;
    localparam int ROW_W        = 11;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        IN_LINE    = 2'd2
    } state_t;

    // Keep the 8 MSBs of each 10-bit lane; lane 0 stays in the low byte.
    function automatic logic [LANES*PIX_W-1:0] trunc_beat(input logic [LANES*RAW_W-1:0] d);
        logic [LANES*PIX_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[PIX_W*i +: PIX_W] = d[RAW_W*i + (RAW_W-PIX_W) +: PIX_W];
        end
        return r;
    endfunction

    function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] c);
        logic [COL_W-1:0] top;
        top = '1;
        return (c > top - COL_W'(LANES)) ? top : c + COL_W'(LANES);
    endfunction

    function automatic logic [ROW_W-1:0] row_step(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] top;
        top = '1;
        return (r == top) ? top : r + ROW_W'(1);
    endfunction

endpackage

// File: rtl/vita2000_window_ctr.sv
// Column/row position tracking for the incoming beat stream and the crop-window compare.
module vita2000_window_ctr
    import vita2000_pkg::*;
#(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480
) (
    input  logic clock,
    input  logic reset_n,
    input  logic frame_sync,
    input  logic line_begin,
    input  logic prev_end,
    input  logic beat,
    input  logic line_finish,
    output logic keep,
    output logic row_keep,
    output logic last_col,
    output logic last_row
);

    localparam logic [COL_W:0]   X_LO     = (COL_W+1)'(X_START);
    localparam logic [COL_W:0]   X_HI     = (COL_W+1)'(X_START + WIDTH);
    localparam logic [ROW_W:0]   Y_LO     = (ROW_W+1)'(Y_START);
    localparam logic [ROW_W:0]   Y_HI     = (ROW_W+1)'(Y_START + HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(X_START + WIDTH - LANES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Y_START + HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_cur;
    logic [ROW_W-1:0] row_q, row_cur;
    logic             col_keep;

    // A line_start that arrives without a line_end closes the previous row first.
    always_comb begin
        col_cur  = line_begin ? '0 : col_q;
        row_cur  = frame_sync ? '0 : (prev_end ? row_step(row_q) : row_q);
        col_keep = ({1'b0, col_cur} >= X_LO) && ({1'b0, col_cur} < X_HI);
        row_keep = ({1'b0, row_cur} >= Y_LO) && ({1'b0, row_cur} < Y_HI);
        keep     = beat && col_keep && row_keep;
        last_col = (col_cur == COL_LAST);
        last_row = (row_cur == ROW_LAST);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= beat ? col_step(col_cur) : col_cur;
            row_q <= line_finish ? row_step(row_cur) : row_cur;
        end
    end

endmodule

// File: rtl/vita2000_pixel_packer.sv
// Crops the VITA2000 beat stream to a window, truncates pixels to 8 bits and
// packs two beats into one 64-bit frame-buffer write with a linear address.
//
//  state      | meaning
//  WAIT_FRAME | idle until frame_start; line traffic ignored
//  WAIT_LINE  | frame open, waiting for line_start with a valid beat
//  IN_LINE    | accepting beats of the current line
module vita2000_pixel_packer
    import vita2000_pkg::*;
#(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int AW      = 19
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pix_valid,
    input  logic [LANES*RAW_W-1:0]       pix_data,
    input  logic                         frame_start,
    input  logic                         line_start,
    input  logic                         line_end,
    output logic [AW-1:0]                w_addr,
    output logic [PIX_PER_WORD*PIX_W-1:0] w_data,
    output logic                         we,
    output logic                         frame_done,
    output logic                         sync_error
);

    state_t                 state;
    logic                   half_q, full_q, par_q, done_pend;
    logic [LANES*PIX_W-1:0] pack_lo, beat_px;
    logic [AW-1:0]          wr_ptr, addr_base;

    logic restart_err, eff_in_line, line_begin, prev_end, beat, line_finish, line_reset;
    logic half_eff, complete, last_word, full_now, par_now, end_err;
    logic keep, row_keep, last_col, last_row;

    vita2000_window_ctr #(
        .X_START (X_START),
        .Y_START (Y_START),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT)
    ) u_window_ctr (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_sync  (frame_start),
        .line_begin  (line_begin),
        .prev_end    (prev_end),
        .beat        (beat),
        .line_finish (line_finish),
        .keep        (keep),
        .row_keep    (row_keep),
        .last_col    (last_col),
        .last_row    (last_row)
    );

    // frame_start takes effect before any line event in the same cycle.
    always_comb begin
        restart_err = frame_start && (state != WAIT_FRAME);
        eff_in_line = (state == IN_LINE) && !frame_start;
        line_begin  = line_start && pix_valid && (frame_start || state != WAIT_FRAME);
        prev_end    = line_begin && eff_in_line;
        beat        = pix_valid && (line_begin || eff_in_line);
        line_finish = line_end && (line_begin || eff_in_line);
        line_reset  = frame_start || line_begin;
        half_eff    = line_reset ? 1'b0 : half_q;
        complete    = keep && half_eff;
        last_word   = complete && last_col && last_row;
        full_now    = (line_reset ? 1'b0 : full_q) || (complete && last_col);
        // An odd beat count inside a window row means a half word was left behind.
        par_now     = (line_reset ? 1'b0 : par_q) ^ beat;
        end_err     = line_finish && !last_word && row_keep && (!full_now || par_now);
        addr_base   = frame_start ? '0 : wr_ptr;
        beat_px     = trunc_beat(pix_data);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= WAIT_FRAME;
            half_q     <= 1'b0;
            full_q     <= 1'b0;
            par_q      <= 1'b0;
            pack_lo    <= '0;
            wr_ptr     <= '0;
            w_addr     <= '0;
            w_data     <= '0;
            we         <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            we         <= complete;
            done_pend  <= last_word;
            frame_done <= done_pend;
            sync_error <= sync_error || restart_err || prev_end || end_err;
            if (keep && !half_eff) pack_lo <= beat_px;
            if (complete) begin
                w_data <= {beat_px, pack_lo};
                w_addr <= addr_base;
            end
            wr_ptr <= complete ? addr_base + AW'(1) : addr_base;
            half_q <= (line_finish || last_word) ? 1'b0 : (keep ? !half_eff : half_eff);
            full_q <= line_finish ? 1'b0 : full_now;
            par_q  <= line_finish ? 1'b0 : par_now;
            if (last_word)        state <= WAIT_FRAME;
            else if (line_finish) state <= WAIT_LINE;
            else if (line_begin)  state <= IN_LINE;
            else if (frame_start) state <= WAIT_LINE;
        end
    end

endmodule

// File: tb/tb_vita2000_pixel_packer.sv
// Directed and randomized bench for the pixel packer: several window
// configurations share one stimulus bus; expected words come from a pixel model.
module tb_vita2000_pixel_packer;

    logic        clock = 1'b0;
    logic        reset_n, pix_valid, frame_start, line_start, line_end;
    logic [39:0] pix_data;

    always #5 clock = ~clock;

    logic [18:0] a_w_addr, b_w_addr, c_w_addr, d_w_addr;
    logic [63:0] a_w_data, b_w_data, c_w_data, d_w_data;
    logic        a_we, b_we, c_we, d_we;
    logic        a_frame_done, b_frame_done, c_frame_done, d_frame_done;
    logic        a_sync_error, b_sync_error, c_sync_error, d_sync_error;

    vita2000_pixel_packer #(.X_START(0), .Y_START(0), .WIDTH(8), .HEIGHT(2), .AW(19)) u_a (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
        .w_addr(a_w_addr), .w_data(a_w_data), .we(a_we),
        .frame_done(a_frame_done), .sync_error(a_sync_error));

    vita2000_pixel_packer #(.X_START(8), .Y_START(1), .WIDTH(8), .HEIGHT(1), .AW(19)) u_b (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
        .w_addr(b_w_addr), .w_data(b_w_data), .we(b_we),
        .frame_done(b_frame_done), .sync_error(b_sync_error));

    vita2000_pixel_packer u_c (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
        .w_addr(c_w_addr), .w_data(c_w_data), .we(c_we),
        .frame_done(c_frame_done), .sync_error(c_sync_error));

    vita2000_pixel_packer #(.X_START(8), .Y_START(2), .WIDTH(16), .HEIGHT(3), .AW(19)) u_d (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
        .w_addr(d_w_addr), .w_data(d_w_data), .we(d_we),
        .frame_done(d_frame_done), .sync_error(d_sync_error));

    logic [63:0] a_qa[$], a_qd[$], b_qa[$], b_qd[$], c_qa[$], c_qd[$], d_qa[$], d_qd[$];
    int a_done_cnt, b_done_cnt, c_done_cnt, d_done_cnt;

    always @(negedge clock) begin
        if (a_we) begin a_qa.push_back(64'(a_w_addr)); a_qd.push_back(a_w_data); end
        if (b_we) begin b_qa.push_back(64'(b_w_addr)); b_qd.push_back(b_w_data); end
        if (c_we) begin c_qa.push_back(64'(c_w_addr)); c_qd.push_back(c_w_data); end
        if (d_we) begin d_qa.push_back(64'(d_w_addr)); d_qd.push_back(d_w_data); end
        if (a_frame_done) a_done_cnt++;
        if (b_frame_done) b_done_cnt++;
        if (c_frame_done) c_done_cnt++;
        if (d_frame_done) d_done_cnt++;
    end

    int          checks   = 0;
    int          failures = 0;
    int          pmode    = 0;
    int          ramp_w   = 8;
    int unsigned seed     = 0;

    // Sensor pixel at (row, col): a ramp n = row*ramp_w + col (value n<<2) or a seeded hash.
    function automatic logic [9:0] pix(input int r, input int c);
        int unsigned h;
        if (pmode == 0) return 10'((r * ramp_w + c) << 2);
        h = seed ^ (32'(r) * 32'h9E3779B1) ^ (32'(c) * 32'h85EBCA77);
        h = h ^ (h >> 13);
        h = h * 32'hC2B2AE3D;
        h = h ^ (h >> 16);
        return h[9:0];
    endfunction

    function automatic logic [39:0] beat_data(input int r, input int c);
        logic [39:0] d;
        for (int k = 0; k < 4; k++) d[10*k +: 10] = pix(r, c + k);
        return d;
    endfunction

    function automatic logic [63:0] exp_word(input int r, input int c);
        logic [63:0] w;
        logic [9:0]  p;
        for (int k = 0; k < 8; k++) begin
            p = pix(r, c + k);
            w[8*k +: 8] = p[9:2];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        a_qa.delete(); a_qd.delete(); b_qa.delete(); b_qd.delete();
        c_qa.delete(); c_qd.delete(); d_qa.delete(); d_qd.delete();
        a_done_cnt = 0; b_done_cnt = 0; c_done_cnt = 0; d_done_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic send_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // gap < 0 selects a random 0..3 idle cycles between beats.
    task automatic send_line(input int r, input int nbeats, input int gap, input bit do_end);
        int g;
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0) begin
                g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                repeat (g) tick();
            end
            pix_valid  = 1'b1;
            pix_data   = beat_data(r, 4 * b);
            line_start = (b == 0);
            line_end   = (b == nbeats - 1) && do_end;
            tick();
            pix_valid  = 1'b0;
            line_start = 1'b0;
            line_end   = 1'b0;
        end
    endtask

    // Expected word a sits at window row a/(w/8), word column a%(w/8).
    task automatic check_q(input string tag, input logic [63:0] qa[$], input logic [63:0] qd[$],
                           input int x0, input int y0, input int w, input int n);
        int wpl, m;
        wpl = w / 8;
        chk({tag, "_count"}, 64'(qa.size()), 64'(n));
        m = (qa.size() < n) ? qa.size() : n;
        for (int a = 0; a < m; a++) begin
            chk({tag, "_addr"}, qa[a], 64'(a));
            chk({tag, "_data"}, qd[a], exp_word(y0 + a / wpl, x0 + 8 * (a % wpl)));
        end
    endtask

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
        line_start = 1'b0; line_end = 1'b0; pix_data = '0;
        clear_mon();
        idle(2);
        chk("reset_we",    64'(a_we),         64'd0);
        chk("reset_addr",  64'(a_w_addr),     64'd0);
        chk("reset_data",  a_w_data,          64'd0);
        chk("reset_done",  64'(a_frame_done), 64'd0);
        chk("reset_error", 64'(a_sync_error), 64'd0);
        reset_n = 1'b1;
        tick();

        // 8x2 ramp window
        pmode = 0; ramp_w = 8;
        clear_mon();
        send_frame_start();
        send_line(0, 2, 0, 1);
        chk("ramp_we0",   64'(a_we),     64'd1);
        chk("ramp_addr0", 64'(a_w_addr), 64'd0);
        chk("ramp_data0", a_w_data,      64'h0706050403020100);
        send_line(1, 2, 0, 1);
        chk("ramp_we1",   64'(a_we),     64'd1);
        chk("ramp_addr1", 64'(a_w_addr), 64'd1);
        chk("ramp_data1", a_w_data,      64'h0F0E0D0C0B0A0908);
        chk("ramp_done_early", 64'(a_frame_done), 64'd0);
        tick();
        chk("ramp_done",  64'(a_frame_done), 64'd1);
        tick();
        chk("ramp_done_pulse", 64'(a_frame_done), 64'd0);
        chk("ramp_error", 64'(a_sync_error), 64'd0);
        chk("ramp_nwr",   64'(a_qa.size()), 64'd2);
        chk("ramp_ndone", 64'(a_done_cnt),  64'd1);

        // offset 8x1 window: only row 1 cols 8..15
        do_reset(); clear_mon();
        pmode = 1; seed = $urandom;
        send_frame_start();
        for (int r = 0; r < 3; r++) send_line(r, 4, -1, 1);
        idle(3);
        check_q("offs", b_qa, b_qd, 8, 1, 8, 1);
        chk("offs_done",  64'(b_done_cnt),   64'd1);
        chk("offs_error", 64'(b_sync_error), 64'd0);

        // gaps between beats
        do_reset(); clear_mon();
        pmode = 0;
        send_frame_start();
        send_line(0, 2, 3, 1);
        chk("gap_we",   64'(a_we), 64'd1);
        chk("gap_nwr",  64'(a_qa.size()), 64'd0);
        chk("gap_data", a_w_data, 64'h0706050403020100);
        send_line(1, 2, -1, 1);
        idle(3);
        check_q("gap", a_qa, a_qd, 0, 0, 8, 2);
        chk("gap_done", 64'(a_done_cnt), 64'd1);

        // odd beat count on a window line
        do_reset(); clear_mon();
        send_frame_start();
        send_line(0, 3, 0, 1);
        idle(1);
        chk("odd_error", 64'(a_sync_error), 64'd1);
        chk("odd_nwr",   64'(a_qa.size()),  64'd1);
        send_line(1, 2, 0, 1);
        idle(3);
        check_q("odd", a_qa, a_qd, 0, 0, 8, 2);

        // reset in the middle of a line
        do_reset(); clear_mon();
        pmode = 1; seed = $urandom | 32'h1;
        send_frame_start();
        send_line(0, 2, 0, 1);
        pix_valid = 1'b1; line_start = 1'b1; pix_data = beat_data(1, 0);
        tick();
        pix_valid = 1'b0; line_start = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("rst_we",    64'(a_we),         64'd0);
        chk("rst_addr",  64'(a_w_addr),     64'd0);
        chk("rst_data",  a_w_data,          64'd0);
        chk("rst_done",  64'(a_frame_done), 64'd0);
        chk("rst_error", 64'(a_sync_error), 64'd0);
        reset_n = 1'b1;
        tick();
        clear_mon();
        send_line(1, 2, 0, 1);
        send_line(0, 2, 0, 1);
        idle(2);
        chk("rst_nowr", 64'(a_qa.size()), 64'd0);
        send_frame_start();
        send_line(0, 2, 0, 1);
        send_line(1, 2, 0, 1);
        idle(3);
        check_q("rst_frame", a_qa, a_qd, 0, 0, 8, 2);
        chk("rst_frame_error", 64'(a_sync_error), 64'd0);

        // randomized 16x3 window at (8,2) inside a 32x6 sensor, two frames
        do_reset();
        for (int f = 0; f < 2; f++) begin
            clear_mon();
            seed = $urandom;
            send_frame_start();
            for (int r = 0; r < 6; r++) send_line(r, 8, -1, 1);
            idle(3);
            check_q("rand", d_qa, d_qd, 8, 2, 16, 6);
            chk("rand_done",  64'(d_done_cnt),   64'd1);
            chk("rand_error", 64'(d_sync_error), 64'd0);
        end

        // frame restart mid-row 1 of the default 640x480 window
        do_reset(); clear_mon();
        seed = $urandom;
        send_frame_start();
        send_line(0, 160, 0, 1);
        send_line(1, 80, 0, 0);
        chk("restart_error_before", 64'(c_sync_error), 64'd0);
        send_frame_start();
        chk("restart_error", 64'(c_sync_error), 64'd1);
        clear_mon();
        for (int r = 0; r < 480; r++) send_line(r, 160, 0, 1);
        idle(3);
        check_q("full", c_qa, c_qd, 0, 0, 640, 38400);
        chk("full_done",  64'(c_done_cnt),   64'd1);
        chk("full_error", 64'(c_sync_error), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
